// File: rtl/slave_daq_tx_buffer.sv
// Transmit buffer between the slave DAQ controller and the USB transmit FIFO.
// Words are queued in an internal FIFO, and DataTransmitDone acknowledges AllDone once the buffer has drained.
module slave_daq_tx_buffer #(
  parameter int ADDR_W    = 9,
  parameter int AFULL_LVL = 500
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] SlaveDaqData,
  input  logic        SlaveDaqData_en,
  input  logic        AllDone,
  input  logic        UsbFifoFull,
  input  logic        ClearStatus,
  output logic [15:0] UsbData,
  output logic        UsbData_en,
  output logic        DataTransmitDone,
  output logic        AlmostFull,
  output logic        Overflow,
  output logic [15:0] TxWordCount
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AFULL_LVL);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t state, stateNext;

  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [ADDR_W:0]   count, countNext;
  logic              full, empty, push, pop, drop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = SlaveDaqData_en && !full;
  assign drop  = SlaveDaqData_en && full;
  assign pop   = !empty && !UsbFifoFull;

  always_comb begin
    countNext = count;
    if (push && !pop)      countNext = count + 1'b1;
    else if (!push && pop) countNext = count - 1'b1;
  end

  // Storage is not reset; the pointers and count alone define what is valid.
  always_ff @(posedge Clk) begin
    if (push) mem[wrPtr] <= SlaveDaqData;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      UsbData    <= '0;
      UsbData_en <= 1'b0;
      AlmostFull <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr   <= rdPtr + 1'b1;
        UsbData <= mem[rdPtr];
      end
      UsbData_en <= pop;
      count      <= countNext;
      AlmostFull <= (countNext >= AF_CNT);
    end
  end

  // A drop in the same cycle as ClearStatus keeps Overflow set.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Overflow    <= 1'b0;
      TxWordCount <= '0;
    end else begin
      if (drop)             Overflow <= 1'b1;
      else if (ClearStatus) Overflow <= 1'b0;
      if (ClearStatus)                               TxWordCount <= '0;
      else if (UsbData_en && TxWordCount != 16'hFFFF) TxWordCount <= TxWordCount + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Leaving DRAIN only needs the FIFO to be empty: a word still showing on UsbData_en has already left.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (AllDone) stateNext = DRAIN;
      DRAIN:   if (!AllDone) stateNext = IDLE;
               else if (empty && !SlaveDaqData_en) stateNext = DONE;
      DONE:    if (!AllDone) stateNext = IDLE;
               else if (SlaveDaqData_en) stateNext = DRAIN;
      default: stateNext = IDLE;
    endcase
  end

  assign DataTransmitDone = (state == DONE);
endmodule

// File: tb/tb_slave_daq_tx_buffer.sv
// Bench for slave_daq_tx_buffer: directed scenarios and a random run, checked against a queue-based model.
module tb_slave_daq_tx_buffer;
  localparam int DEPTH = 512;
  localparam int AFL   = 500;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] SlaveDaqData = '0;
  logic        SlaveDaqData_en = 1'b0, AllDone = 1'b0, UsbFifoFull = 1'b0, ClearStatus = 1'b0;
  logic [15:0] UsbData, TxWordCount;
  logic        UsbData_en, DataTransmitDone, AlmostFull, Overflow;

  slave_daq_tx_buffer #(.ADDR_W(9), .AFULL_LVL(AFL)) dut (
    .Clk(Clk), .reset_n(reset_n), .SlaveDaqData(SlaveDaqData), .SlaveDaqData_en(SlaveDaqData_en),
    .AllDone(AllDone), .UsbFifoFull(UsbFifoFull), .ClearStatus(ClearStatus), .UsbData(UsbData),
    .UsbData_en(UsbData_en), .DataTransmitDone(DataTransmitDone), .AlmostFull(AlmostFull),
    .Overflow(Overflow), .TxWordCount(TxWordCount));

  always #5 Clk = ~Clk;

  int nchk = 0, nfail = 0;

  // Reference model: word queue, expected outputs, and end-of-run phase (0 idle, 1 drain, 2 done).
  logic [15:0] mq[$];
  logic        mEn, mOvf, mAf;
  logic [15:0] mData, mCnt;
  int          mSt;

  function automatic void model_reset();
    mq.delete();
    mEn = 0; mOvf = 0; mAf = 0; mData = 0; mCnt = 0; mSt = 0;
  endfunction

  task automatic tick(input logic en, input logic [15:0] d, input logic uf, input logic ad, input logic clr);
    int sz;
    logic popN, pushN;
    SlaveDaqData_en = en; SlaveDaqData = d; UsbFifoFull = uf; AllDone = ad; ClearStatus = clr;
    @(posedge Clk);
    sz = mq.size();
    popN = (sz > 0) && !uf;
    pushN = en && (sz < DEPTH);
    if (clr) mCnt = 0;
    else if (mEn && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    if (en && !pushN) mOvf = 1;
    else if (clr) mOvf = 0;
    case (mSt)
      0: if (ad) mSt = 1;
      1: if (!ad) mSt = 0; else if (sz == 0 && !en) mSt = 2;
      default: if (!ad) mSt = 0; else if (en) mSt = 1;
    endcase
    mEn = popN;
    if (popN) mData = mq.pop_front();
    if (pushN) mq.push_back(d);
    mAf = (mq.size() >= AFL);
    #1;
  endtask

  task automatic test_reset();
    nchk++;
    if ({UsbData, UsbData_en, DataTransmitDone, AlmostFull, Overflow, TxWordCount} !== 36'd0) begin
      nfail++;
      $display("FAIL reset_vals: got data=%h en=%b done=%b af=%b ovf=%b cnt=%h, want all 0",
               UsbData, UsbData_en, DataTransmitDone, AlmostFull, Overflow, TxWordCount);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 9; i++) begin
      tick(i < 5, 16'(i + 1), 0, 0, 0);
      nchk++;
      if (UsbData_en !== (i >= 1 && i <= 5) || ((i >= 1 && i <= 5) && UsbData !== 16'(i))) begin
        nfail++;
        $display("FAIL stream_t%0d: got en=%b data=%h want en=%b data=%h", i, UsbData_en, UsbData, (i >= 1 && i <= 5), i);
      end
    end
    nchk++;
    if (TxWordCount !== 16'd5) begin
      nfail++; $display("FAIL stream_cnt: got %0d want 5", TxWordCount);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w[$];
    int got;
    for (int i = 0; i < 10; i++) begin
      w.push_back(16'($urandom));
      tick(1, w[i], 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0);
    nchk++;
    if (UsbData_en !== 1'b0) begin nfail++; $display("FAIL bp_stall: got en=%b want 0", UsbData_en); end
    got = 0;
    for (int i = 0; i < 14; i++) begin
      tick(0, 0, 0, 0, 0);
      if (UsbData_en === 1'b1) begin
        nchk++;
        if (got >= 10 || UsbData !== w[got]) begin
          nfail++; $display("FAIL bp_word%0d: got %h want %h", got, UsbData, (got < 10) ? w[got] : 16'hx);
        end
        got++;
      end
    end
    nchk++;
    if (got != 10 || Overflow !== 1'b0) begin
      nfail++; $display("FAIL bp_total: got words=%0d ovf=%b want 10 and 0", got, Overflow);
    end
  endtask

  task automatic test_overflow();
    int got;
    for (int k = 1; k <= DEPTH + 3; k++) begin
      tick(1, 16'(k * 7), 1, 0, 0);
      if (k >= 495 && k <= 505 || k >= DEPTH) begin
        nchk++;
        if (AlmostFull !== (k >= AFL) || Overflow !== (k > DEPTH)) begin
          nfail++; $display("FAIL ovf_fill_k%0d: got af=%b ovf=%b want af=%b ovf=%b", k, AlmostFull, Overflow, k >= AFL, k > DEPTH);
        end
      end
    end
    tick(0, 0, 1, 0, 1);
    nchk++;
    if (Overflow !== 1'b0 || TxWordCount !== 16'd0) begin
      nfail++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d want 0 0", Overflow, TxWordCount);
    end
    got = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      tick(0, 0, 0, 0, 0);
      if (UsbData_en === 1'b1) begin
        got++;
        nchk++;
        if (UsbData !== 16'(got * 7) || UsbData !== mData) begin
          nfail++; $display("FAIL ovf_drain%0d: got %h want %h", got, UsbData, 16'(got * 7));
        end
      end
    end
    nchk++;
    if (got != DEPTH || AlmostFull !== 1'b0) begin
      nfail++; $display("FAIL ovf_drain_total: got %0d af=%b want %0d af=0", got, AlmostFull, DEPTH);
    end
  endtask

  task automatic test_end_of_run();
    logic [15:0] tail[4];
    int lastEn, doneAt;
    tail[0] = 16'hFF45; tail[1] = 16'hCC3A; tail[2] = 16'h1234; tail[3] = 16'h45FF;
    for (int i = 0; i < 4; i++) tick(1, tail[i], 0, 0, 0);
    lastEn = -1; doneAt = -1;
    for (int i = 0; i < 30 && doneAt < 0; i++) begin
      tick(0, 0, 0, 1, 0);
      if (UsbData_en === 1'b1) lastEn = i;
      if (DataTransmitDone === 1'b1) doneAt = i;
    end
    nchk++;
    if (doneAt < 0 || doneAt != lastEn + 1 || UsbData !== 16'h45FF) begin
      nfail++; $display("FAIL eor_done: done at %0d last en at %0d data=%h want done at last+1, data 45ff", doneAt, lastEn, UsbData);
    end
    tick(0, 0, 0, 1, 0);
    nchk++;
    if (DataTransmitDone !== 1'b1) begin nfail++; $display("FAIL eor_hold: got %b want 1", DataTransmitDone); end
    tick(0, 0, 0, 0, 0);
    nchk++;
    if (DataTransmitDone !== 1'b0) begin nfail++; $display("FAIL eor_drop: got %b want 0", DataTransmitDone); end
  endtask

  task automatic test_toggle_drain();
    int got;
    for (int i = 0; i < 3; i++) tick(1, 16'hA0 + 16'(i), 1, 0, 0);
    got = 0;
    for (int i = 0; i < 40 && DataTransmitDone !== 1'b1; i++) begin
      tick(0, 0, (i % 2) == 0, 1, 0);
      if (UsbData_en === 1'b1) got++;
      if (got < 3) begin
        nchk++;
        if (DataTransmitDone !== 1'b0) begin nfail++; $display("FAIL tog_early: done=1 after %0d words want 0", got); end
      end
    end
    nchk++;
    if (DataTransmitDone !== 1'b1 || got != 3) begin
      nfail++; $display("FAIL tog_done: got done=%b words=%0d want 1 and 3", DataTransmitDone, got);
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic ad, en, uf, clr;
    ad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) ad = ~ad;
      en  = ($urandom_range(0, 9) < 6);
      uf  = (i % 150 > 100) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      clr = ($urandom_range(0, 39) == 0);
      tick(en, 16'($urandom), uf, ad, clr);
      nchk++;
      if ({UsbData_en, UsbData, DataTransmitDone, AlmostFull, Overflow, TxWordCount} !==
          {mEn, mData, mSt == 2, mAf, mOvf, mCnt}) begin
        nfail++;
        $display("FAIL rand_c%0d: got en=%b d=%h done=%b af=%b ovf=%b cnt=%0d want en=%b d=%h done=%b af=%b ovf=%b cnt=%0d",
                 i, UsbData_en, UsbData, DataTransmitDone, AlmostFull, Overflow, TxWordCount,
                 mEn, mData, mSt == 2, mAf, mOvf, mCnt);
      end
    end
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 22; i++) tick(1, 16'h500 + 16'(i), i < 20, 0, 0);
    reset_n = 0;
    model_reset();
    #2;
    nchk++;
    if ({UsbData, UsbData_en, DataTransmitDone, AlmostFull, Overflow, TxWordCount} !== 36'd0) begin
      nfail++;
      $display("FAIL rst_mid: got data=%h en=%b done=%b af=%b ovf=%b cnt=%h want all 0",
               UsbData, UsbData_en, DataTransmitDone, AlmostFull, Overflow, TxWordCount);
    end
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 0);
      nchk++;
      if (UsbData_en !== 1'b0) begin nfail++; $display("FAIL rst_quiet%0d: got en=%b want 0", i, UsbData_en); end
    end
    tick(1, 16'hBEEF, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    nchk++;
    if (UsbData_en !== 1'b1 || UsbData !== 16'hBEEF) begin
      nfail++; $display("FAIL rst_after: got en=%b data=%h want 1 beef", UsbData_en, UsbData);
    end
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    @(negedge Clk);
    reset_n = 1;
    test_stream();
    test_backpressure();
    test_overflow();
    test_end_of_run();
    test_toggle_drain();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
